alu_share_ctrl: RTL and testbench

- Sequencer/arbiter that shares one combinational ALU instance between two requesters, e.g. the main datapath and a branch/address helper.
- Accepts one operation at a time through a valid/ready handshake and drives the ALU operand and control lines.
- Holds the ALU inputs stable for the operation's latency, then returns the registered result and zero flag to the requester that issued it.
- Multiply (ctrl 3) is treated as a multi-cycle operation; all other codes complete in one execute cycle.

---
 rtl/alu_share_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin arbitration,
// operand hold for the operation latency, and a registered single-cycle response.
module alu_share_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_src1_i,
  input  logic [WIDTH-1:0] req0_src2_i,
  input  logic [3:0]       req0_ctrl_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_src1_i,
  input  logic [WIDTH-1:0] req1_src2_i,
  input  logic [3:0]       req1_ctrl_i,

  output logic             resp0_valid_o,
  output logic             resp1_valid_o,
  output logic [WIDTH-1:0] resp_result_o,
  output logic             resp_zero_o,

  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i
);

  localparam logic [3:0] CTRL_MUL = 4'd3;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             id_reg;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] src1_reg, src2_reg, result_reg;
  logic [3:0]       ctrl_reg;
  logic             zero_reg;

  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] sel_src1, sel_src2;
  logic [3:0]       sel_ctrl;

  // With both requesters pending, the one that did not win last time is granted.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = ~last_grant_reg;
    end else begin
      grant_id = req1_valid_i;
    end
  end

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign accept       = !rst_i && (state_reg == IDLE) && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = accept && !grant_id;
  assign req1_ready_o = accept && grant_id;

  assign sel_src1 = grant_id ? req1_src1_i : req0_src1_i;
  assign sel_src2 = grant_id ? req1_src2_i : req0_src2_i;
  assign sel_ctrl = grant_id ? req1_ctrl_i : req0_ctrl_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      cnt_reg        <= 4'd0;
      src1_reg       <= '0;
      src2_reg       <= '0;
      ctrl_reg       <= 4'd0;
      result_reg     <= '0;
      zero_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            src1_reg       <= sel_src1;
            src2_reg       <= sel_src2;
            ctrl_reg       <= sel_ctrl;
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            cnt_reg        <= (sel_ctrl == CTRL_MUL) ? MUL_LOAD : 4'd0;
          end
        end
        EXEC: begin
          // The ALU is assumed settled by the last execute cycle; sample it there.
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            result_reg <= alu_result_i;
            zero_reg   <= alu_zero_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp0_valid_o = (state_reg == RESP) && !id_reg;
  assign resp1_valid_o = (state_reg == RESP) && id_reg;
  assign resp_result_o = result_reg;
  assign resp_zero_o   = zero_reg;
  assign alu_src1_o    = src1_reg;
  assign alu_src2_o    = src2_reg;
  assign alu_ctrl_o    = ctrl_reg;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU stub, a vector table, hand-built
// corner sequences (contention, blocking, reset mid-op) and random operations.
module tb_alu_share_ctrl;
  localparam int W   = 32;
  localparam int MUL = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0v, r0r, r1v, r1r;
  logic [W-1:0] r0a, r0b, r1a, r1b;
  logic [3:0]   r0c, r1c;
  logic         p0, p1, rz;
  logic [W-1:0] rres;
  logic [W-1:0] as1, as2, ares;
  logic [3:0]   actl;
  logic         azero;

  int passed = 0;
  int total  = 0;

  alu_share_ctrl #(.WIDTH(W), .MUL_CYCLES(MUL)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(r0v), .req0_ready_o(r0r), .req0_src1_i(r0a), .req0_src2_i(r0b), .req0_ctrl_i(r0c),
    .req1_valid_i(r1v), .req1_ready_o(r1r), .req1_src1_i(r1a), .req1_src2_i(r1b), .req1_ctrl_i(r1c),
    .resp0_valid_o(p0), .resp1_valid_o(p1), .resp_result_o(rres), .resp_zero_o(rz),
    .alu_src1_o(as1), .alu_src2_o(as2), .alu_ctrl_o(actl),
    .alu_result_i(ares), .alu_zero_i(azero)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: the result any requester should see for a given operation.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a * b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    ares  = alu_fn(actl, as1, as2);
    azero = (ares == '0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    if (id) begin r1v = v; r1a = a; r1b = b; r1c = c; end
    else    begin r0v = v; r0a = a; r0b = b; r0c = c; end
  endtask

  // Issue one op from requester id starting at a negedge; checks latency, result and hold.
  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                       input logic [W-1:0] er, input logic ez, input string tag);
    int n;
    int lat;
    bit hold_ok;
    drive(id, 1'b1, a, b, c);
    #1;
    n = 0;
    while (!(id ? r1r : r0r) && n < 50) begin @(negedge clk); #1; n++; end
    chk({tag, "_ready_seen"}, 32'(n < 50), 32'd1);
    chk({tag, "_one_ready"}, 32'(r0r & r1r), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(id, 1'b0, '0, '0, 4'd0);
    lat = 1;
    hold_ok = 1'b1;
    while (!(p0 | p1) && lat < 40) begin
      if (as1 !== a || as2 !== b || actl !== c || r0r || r1r) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
    chk({tag, "_latency"}, 32'(lat), (c == 4'd3) ? 32'(MUL + 1) : 32'd2);
    chk({tag, "_resp_own"}, 32'(id ? p1 : p0), 32'd1);
    chk({tag, "_resp_other"}, 32'(id ? p0 : p1), 32'd0);
    chk({tag, "_result"}, rres, er);
    chk({tag, "_zero"}, 32'(rz), 32'(ez));
    @(negedge clk);
    chk({tag, "_pulse_len"}, 32'(p0 | p1), 32'd0);
    chk({tag, "_result_hold"}, rres, er);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 4'd0);
    drive(1'b1, 1'b0, '0, '0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0] c;
    logic [W-1:0] er;
    logic       ez;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b0, 32'd5,  32'd7,  4'd2,  32'd12,         1'b0};
    vt[1] = '{1'b1, 32'd6,  32'd7,  4'd3,  32'd42,         1'b0};
    vt[2] = '{1'b0, 32'd9,  32'd9,  4'd6,  32'd0,          1'b1};
    vt[3] = '{1'b1, 32'd1,  32'd2,  4'd1,  32'd3,          1'b0};
    vt[4] = '{1'b0, 32'd4,  32'd8,  4'd9,  32'd0,          1'b1};
    vt[5] = '{1'b1, 32'h0,  32'h0,  4'd12, 32'hFFFF_FFFF,  1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b1, 32'd5, 32'd7, 4'd2);
    drive(1'b1, 1'b0, '0, '0, 4'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", 32'(r0r), 32'd0);
    chk("rst_resp", 32'({p0, p1}), 32'd0);
    chk("rst_result", rres, 32'd0);
    chk("rst_alu_src1", as1, 32'd0);
    chk("rst_alu_ctrl", 32'(actl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_ready_after_rst", 32'(r0r), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 4'd0);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(vt[i].id, vt[i].a, vt[i].b, vt[i].c, vt[i].er, vt[i].ez, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Contention: both requesters valid every cycle; grants must alternate from 0.
    begin
      int grants[$];
      int cyc;
      bit never_two;
      int r0_seen;
      int r1_seen;
      do_reset();
      drive(1'b0, 1'b1, 32'd9, 32'd9, 4'd6);
      drive(1'b1, 1'b1, 32'd1, 32'd2, 4'd1);
      never_two = 1'b1;
      r0_seen = 0;
      r1_seen = 0;
      cyc = 0;
      while (grants.size() < 4 && cyc < 60) begin
        #1;
        if (r0r && r1r) never_two = 1'b0;
        if (r0r) grants.push_back(0);
        if (r1r) grants.push_back(1);
        if (p0) begin chk("cont_r0_result", rres, 32'd0); chk("cont_r0_zero", 32'(rz), 32'd1); r0_seen++; end
        if (p1) begin chk("cont_r1_result", rres, 32'd3); r1_seen++; end
        @(negedge clk);
        cyc++;
      end
      drive(1'b0, 1'b0, '0, '0, 4'd0);
      drive(1'b1, 1'b0, '0, '0, 4'd0);
      chk("cont_never_two_ready", 32'(never_two), 32'd1);
      chk("cont_grant_count", 32'(grants.size()), 32'd4);
      for (int i = 0; i < grants.size(); i++)
        chk($sformatf("cont_grant%0d", i), 32'(grants[i]), 32'(i % 2));
      chk("cont_resps_seen", 32'(r0_seen + r1_seen), 32'd3);
      repeat (6) @(negedge clk);
    end

    // Blocked: req1 raises valid during req0's multiply and must wait for IDLE.
    begin
      int n;
      bit blocked_ok;
      drive(1'b0, 1'b1, 32'd3, 32'd4, 4'd3);
      #1;
      n = 0;
      while (!r0r && n < 20) begin @(negedge clk); #1; n++; end
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 4'd0);
      drive(1'b1, 1'b1, 32'd10, 32'd20, 4'd2);
      #1;
      blocked_ok = 1'b1;
      n = 0;
      while (!p0 && n < 20) begin
        if (r1r) blocked_ok = 1'b0;
        @(negedge clk); #1; n++;
      end
      if (r1r) blocked_ok = 1'b0;
      chk("blk_no_ready_while_busy", 32'(blocked_ok), 32'd1);
      chk("blk_r0_result", rres, 32'd12);
      @(negedge clk);
      #1;
      chk("blk_ready_in_idle", 32'(r1r), 32'd1);
      @(negedge clk);
      n = 0;
      while (!p1 && n < 20) begin @(negedge clk); n++; end
      // The pending request is accepted in IDLE at its first cycle, so its issue() re-drive is unnecessary.
      chk("blk_r1_resp", 32'(p1), 32'd1);
      chk("blk_r1_result", rres, 32'd30);
      drive(1'b1, 1'b0, '0, '0, 4'd0);
      repeat (3) @(negedge clk);
    end

    // Reset during a multiply's execute phase drops it without a response.
    begin
      int n;
      bit no_pulse;
      drive(1'b0, 1'b1, 32'd6, 32'd7, 4'd3);
      #1;
      n = 0;
      while (!r0r && n < 20) begin @(negedge clk); #1; n++; end
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 4'd0);
      rst = 1'b1;
      #1;
      chk("midrst_alu_src1", as1, 32'd0);
      chk("midrst_alu_ctrl", 32'(actl), 32'd0);
      chk("midrst_result", rres, 32'd0);
      no_pulse = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (p0 || p1) no_pulse = 1'b0;
        @(negedge clk);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        #1;
        if (p0 || p1) no_pulse = 1'b0;
        @(negedge clk);
      end
      chk("midrst_no_pulse", 32'(no_pulse), 32'd1);
      issue(1'b0, 32'd3, 32'd5, 4'd7, 32'd1, 1'b0, "post_rst_slt");
    end

    // Random operations against the behavioural ALU result.
    for (int i = 0; i < 25; i++) begin
      bit           id;
      logic [3:0]   c;
      logic [W-1:0] a, b, e;
      id = 1'($urandom_range(0, 1));
      c  = 4'($urandom_range(0, 15));
      a  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      e  = alu_fn(c, a, b);
      issue(id, a, b, c, e, (e == '0), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
